// File: rtl/trivium_host.sv
// Host-side initiator for Trivium_Comp: takes one key/IV request, runs the core's
// Krdy/Kvld and Drdy/BSY handshakes, then streams the Dout block out MSW first.
// Optional timeout on core waits: define TRIVIUM_HOST_TIMEOUT_EN.
module trivium_host #(
  parameter int WORD_W  = 32,
  parameter int DOUT_W  = 4096,
  parameter int TIMEOUT = 8192
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [79:0]       req_key,
  input  logic [79:0]       req_iv,
  input  logic              req_dec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              err,
  output logic [79:0]       Kin,
  output logic [79:0]       Din,
  output logic              EncDec,
  output logic              Krdy,
  output logic              Drdy,
  output logic              EN,
  input  logic [DOUT_W-1:0] Dout,
  input  logic              BSY,
  input  logic              Kvld,
  input  logic              Dvld
);

  localparam int N_WORDS = DOUT_W / WORD_W;
  localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_KEY, S_IV, S_RUN, S_SEND} state_t;

  state_t state_q, state_d;

  logic              req_ready_q, req_ready_d;
  logic              krdy_q, krdy_d;
  logic              drdy_q, drdy_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              err_q, err_d;
  logic              en_q, en_d;
  logic              enc_dec_q, enc_dec_d;
  logic [79:0]       kin_q, kin_d;
  logic [79:0]       din_q, din_d;
  logic [DOUT_W-1:0] ks_q, ks_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic accept;
  logic word_acc;
  logic timeout_fire;

  // Both ports transfer on a cycle where valid and ready are high at the rising
  // edge; a valid source holds its payload stable until that transfer happens.
  assign accept   = (state_q == S_IDLE) && req_ready_q && req_valid;
  assign word_acc = (state_q == S_SEND) && out_valid_q && out_ready;

`ifdef TRIVIUM_HOST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting;
  logic             progress;

  assign waiting  = (state_q == S_KEY) || (state_q == S_IV) || (state_q == S_RUN);
  assign progress = ((state_q == S_KEY) && Kvld) || ((state_q == S_IV) && BSY) ||
                    ((state_q == S_RUN) && Dvld);
  // A handshake landing on the final allowed cycle still wins over the timeout.
  assign timeout_fire = waiting && !progress && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (waiting)       cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout_fire = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept)                state_d = S_KEY;
      S_KEY:   if (Kvld)                  state_d = S_IV;
      S_IV:    if (BSY)                   state_d = S_RUN;
      S_RUN:   if (Dvld)                  state_d = S_SEND;
      S_SEND:  if (word_acc && out_last_q) state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
    if (timeout_fire) state_d = S_IDLE;
  end

  always_comb begin
    // After a timeout the err cycle comes first; req_ready rises one cycle later.
    req_ready_d = (state_d == S_IDLE) && !timeout_fire;
    krdy_d      = (state_d == S_KEY);
    drdy_d      = (state_d == S_IV);
    out_valid_d = (state_d == S_SEND);
    err_d       = timeout_fire;
    en_d        = 1'b1;
    kin_d       = kin_q;
    din_d       = din_q;
    enc_dec_d   = enc_dec_q;
    ks_d        = ks_q;
    idx_d       = idx_q;
    if (accept) begin
      kin_d     = req_key;
      din_d     = req_iv;
      enc_dec_d = req_dec;
    end
    // The block shifts up one word per transfer, so the top word is always next.
    if ((state_q == S_RUN) && Dvld) begin
      ks_d  = Dout;
      idx_d = '0;
    end else if (word_acc) begin
      ks_d = ks_q << WORD_W;
      if (!out_last_q) idx_d = idx_q + IDX_W'(1);
    end
    out_last_d = (state_d == S_SEND) && (idx_d == LAST_IDX);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      req_ready_q <= 1'b0;
      krdy_q      <= 1'b0;
      drdy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      en_q        <= 1'b0;
      enc_dec_q   <= 1'b0;
      kin_q       <= '0;
      din_q       <= '0;
      ks_q        <= '0;
      idx_q       <= '0;
    end else begin
      req_ready_q <= req_ready_d;
      krdy_q      <= krdy_d;
      drdy_q      <= drdy_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      en_q        <= en_d;
      enc_dec_q   <= enc_dec_d;
      kin_q       <= kin_d;
      din_q       <= din_d;
      ks_q        <= ks_d;
      idx_q       <= idx_d;
    end
  end

  assign req_ready = req_ready_q;
  assign Krdy      = krdy_q;
  assign Drdy      = drdy_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = ks_q[DOUT_W-1 -: WORD_W];
  assign err       = err_q;
  assign EN        = en_q;
  assign EncDec    = enc_dec_q;
  assign Kin       = kin_q;
  assign Din       = din_q;

endmodule

// File: tb/tb_trivium_host.sv
// Bench for trivium_host: behavioural core model, random keystream blocks, and a
// scoreboard of expected {last, word} entries checked by an output monitor.
module tb_trivium_host;

  localparam int WORD_W  = 32;
  localparam int DOUT_W  = 4096;
  localparam int N_WORDS = DOUT_W / WORD_W;
  localparam int TMO     = 16;

  logic              CLK, RST;
  logic              req_valid, req_ready, req_dec;
  logic [79:0]       req_key, req_iv;
  logic              out_valid, out_ready, out_last, err;
  logic [WORD_W-1:0] out_data;
  logic [79:0]       Kin, Din;
  logic              EncDec, Krdy, Drdy, EN;
  logic [DOUT_W-1:0] Dout;
  logic              BSY, Kvld, Dvld;

  logic              core_en, core_kvld, core_bsy, core_dvld;
  logic [DOUT_W-1:0] core_dout;
  logic              spur_bsy, spur_dvld, bp_mode;

  logic [WORD_W:0]   exp_q[$];
  logic [DOUT_W-1:0] blk_q[$];

  int checks, failures, cyc, words_acc, last_cyc, last_seen;
  logic              stall_prev, prev_last, kv_prev, bs_prev;
  logic [WORD_W-1:0] prev_data;

  assign Dout = core_dout;
  assign Kvld = core_kvld;
  assign BSY  = core_bsy | spur_bsy;
  assign Dvld = core_dvld | spur_dvld;

  trivium_host #(.WORD_W(WORD_W), .DOUT_W(DOUT_W), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_iv(req_iv),
    .req_dec(req_dec),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err(err), .Kin(Kin), .Din(Din), .EncDec(EncDec), .Krdy(Krdy), .Drdy(Drdy), .EN(EN),
    .Dout(Dout), .BSY(BSY), .Kvld(Kvld), .Dvld(Dvld)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    #1;
    out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- core model ----------------
  initial begin
    core_kvld = 1'b0; core_bsy = 1'b0; core_dvld = 1'b0; core_dout = '0;
    forever begin
      @(posedge CLK); #1;
      if (core_en && Krdy && !RST) begin
        repeat (2) @(posedge CLK);
        #1 core_kvld = 1'b1;
        @(posedge CLK); #1 core_kvld = 1'b0;
        for (int i = 0; i < 50 && !Drdy; i++) begin @(posedge CLK); #1; end
        if (Drdy) begin
          @(posedge CLK); #1 core_bsy = 1'b1;
          repeat (3) @(posedge CLK);
          #1 core_bsy = 1'b0;
          @(posedge CLK); #1;
          core_dout = (blk_q.size() > 0) ? blk_q.pop_front() : '0;
          core_dvld = 1'b1;
          @(posedge CLK); #1 core_dvld = 1'b0;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic push_block();
    logic [DOUT_W-1:0] b, t;
    for (int i = 0; i < DOUT_W / 32; i++) b[i*32 +: 32] = $urandom();
    blk_q.push_back(b);
    for (int w = 0; w < N_WORDS; w++) begin
      t = b >> ((N_WORDS - 1 - w) * WORD_W);
      exp_q.push_back({(w == N_WORDS - 1), t[WORD_W-1:0]});
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    logic [WORD_W:0] e;
    if (!RST) begin
      chk("krdy_drdy_exclusive", Krdy & Drdy, 0);
      if (kv_prev) begin
        chk("krdy_drop_after_kvld", Krdy, 0);
        chk("drdy_after_kvld", Drdy, 1);
      end
      if (bs_prev) chk("drdy_drop_after_bsy", Drdy, 0);
      if (stall_prev && out_valid) begin
        chk("stall_data_hold", out_data, prev_data);
        chk("stall_last_hold", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("word_data", out_data, e[WORD_W-1:0]);
          chk("word_last", out_last, e[WORD_W]);
          words_acc++;
          if (e[WORD_W]) last_cyc = cyc;
          if (out_last) last_seen++;
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      kv_prev    = Krdy && Kvld;
      bs_prev    = Drdy && BSY;
    end else begin
      stall_prev = 1'b0;
      kv_prev    = 1'b0;
      bs_prev    = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_vals();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err", err, 0);
    chk("rst_kin", Kin, 0);
    chk("rst_din", Din, 0);
    chk("rst_encdec", EncDec, 0);
    chk("rst_krdy", Krdy, 0);
    chk("rst_drdy", Drdy, 0);
    chk("rst_en", EN, 0);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1 RST = 1'b1; req_valid = 1'b0;
    @(posedge CLK); @(negedge CLK);
    check_reset_vals();
    @(posedge CLK); #1 RST = 1'b0;
    exp_q.delete(); blk_q.delete();
    @(negedge CLK); @(negedge CLK);
    chk("req_ready_after_rst", req_ready, 1);
    chk("en_after_rst", EN, 1);
  endtask

  task automatic send_req(input logic [79:0] k, input logic [79:0] v, input logic d);
    int n = 0;
    @(posedge CLK); #1;
    req_key = k; req_iv = v; req_dec = d; req_valid = 1'b1;
    @(negedge CLK);
    while (!req_ready && n < 500) begin @(negedge CLK); n++; end
    if (!req_ready) begin
      chk("req_accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge CLK); #1 req_valid = 1'b0;
    @(negedge CLK);
    chk("kin_latched", Kin, k);
    chk("din_latched", Din, v);
    chk("encdec_latched", EncDec, d);
    chk("krdy_after_accept", Krdy, 1);
    chk("req_ready_busy", req_ready, 0);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin @(negedge CLK); n++; end
    chk("drain_done", exp_q.size(), 0);
    exp_q.delete();
  endtask

  function automatic logic [79:0] rnd80();
    return {16'($urandom()), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n, bad, kc;
    logic [79:0] k2;
    RST = 1'b1; req_valid = 1'b0; req_key = '0; req_iv = '0; req_dec = 1'b0;
    core_en = 1'b1; spur_bsy = 1'b0; spur_dvld = 1'b0; bp_mode = 1'b0;
    do_reset();

    // nominal
    words_acc = 0; last_seen = 0;
    push_block();
    send_req(80'hFF000102030405060708, 80'h0, 1'b0);
    wait_drain(2000);
    chk("nominal_words", words_acc, N_WORDS);
    chk("nominal_last_count", last_seen, 1);
    chk("nominal_encdec", EncDec, 0);

    // backpressure
    bp_mode = 1'b1; words_acc = 0; last_seen = 0;
    push_block();
    send_req(rnd80(), rnd80(), 1'b0);
    wait_drain(4000);
    chk("bp_words", words_acc, N_WORDS);
    chk("bp_last_count", last_seen, 1);
    bp_mode = 1'b0;

    // back-to-back
    k2 = 80'h0123456789ABCDEF0011;
    words_acc = 0;
    push_block();
    send_req(rnd80(), rnd80(), 1'b0);
    push_block();
    req_key = k2; req_iv = rnd80(); req_dec = 1'b1; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 3000) begin @(negedge CLK); n++; end
    chk("b2b_ready_after_last", cyc, last_cyc + 1);
    @(posedge CLK); #1 req_valid = 1'b0;
    @(negedge CLK);
    chk("b2b_kin", Kin, k2);
    chk("b2b_encdec", EncDec, 1);
    chk("b2b_krdy", Krdy, 1);
    wait_drain(3000);
    chk("b2b_words", words_acc, 2 * N_WORDS);

    // reset mid-stream
    words_acc = 0; last_seen = 0;
    push_block();
    send_req(rnd80(), rnd80(), 1'b1);
    n = 0;
    while (words_acc < 40 && n < 2000) begin @(posedge CLK); n++; end
    chk("mid_reached_40", words_acc, 40);
    #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    check_reset_vals();
    repeat (5) @(negedge CLK);
    chk("mid_no_last", last_seen, 0);
    chk("mid_req_ready", req_ready, 1);
    words_acc = 0;
    push_block();
    send_req(rnd80(), rnd80(), 1'b0);
    wait_drain(2000);
    chk("mid_recover_words", words_acc, N_WORDS);
    chk("mid_recover_last", last_seen, 1);

    // timeout / indefinite wait
    core_en = 1'b0;
    send_req(rnd80(), rnd80(), 1'b0);
`ifdef TRIVIUM_HOST_TIMEOUT_EN
    kc = 1;
    @(negedge CLK);
    while (Krdy && kc < 100) begin kc++; @(negedge CLK); end
    chk("tmo_krdy_cycles", kc, TMO);
    chk("tmo_krdy_low", Krdy, 0);
    chk("tmo_err_pulse", err, 1);
    chk("tmo_ready_not_yet", req_ready, 0);
    @(negedge CLK);
    chk("tmo_err_single", err, 0);
    chk("tmo_req_ready", req_ready, 1);
`else
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (!Krdy || err) bad++;
    end
    chk("notmo_krdy_held", bad, 0);
    kc = 0;
`endif
    do_reset();

    // spurious core signals
    @(posedge CLK); #1 spur_bsy = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge CLK);
      if (!req_ready || out_valid || Krdy || Drdy) bad++;
    end
    chk("spur_bsy_idle", bad, 0);
    @(posedge CLK); #1 spur_bsy = 1'b0;
    send_req(rnd80(), rnd80(), 1'b0);
    @(posedge CLK); #1 spur_dvld = 1'b1;
    @(posedge CLK); #1 spur_dvld = 1'b0;
    @(negedge CLK);
    chk("spur_dvld_krdy", Krdy, 1);
    chk("spur_dvld_drdy", Drdy, 0);
    chk("spur_dvld_out_valid", out_valid, 0);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=expired required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trivium_host.md
# trivium_host

Host-side initiator for the Trivium core's key/IV load interface. It accepts a key/IV request over a valid/ready port and runs the core's Krdy/Kvld and Drdy/BSY handshakes. It then captures the core's wide keystream output on Dvld and streams it out as fixed-width words. It sits between the system bus bridge and `Trivium_Comp`, replacing bench-driven stimulus in the integrated design.

## Interface
Parameters:
- WORD_W, 32, output word width; DOUT_W must be an integer multiple of it
- DOUT_W, 4096, core keystream (Dout) width
- TIMEOUT, 8192, max cycles spent in any one core-wait state (only with timeout macro)

Ports:
- CLK  in  1  system clock; everything is synchronous to its rising edge
- RST  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  host can accept a request
- req_key  in  80  key
- req_iv  in  80  IV
- req_dec  in  1  0: encryption, 1: decryption
- out_valid  out  1  keystream word present
- out_ready  in  1  downstream accepts word
- out_data  out  WORD_W  keystream word
- out_last  out  1  final word of the block
- err  out  1  one-cycle timeout pulse
- Kin  out  80  key to core
- Din  out  80  IV to core
- EncDec  out  1  mode to core
- Krdy  out  1  key ready to core
- Drdy  out  1  data ready to core
- EN  out  1  core enable
- Dout  in  DOUT_W  core keystream
- BSY  in  1  core busy
- Kvld  in  1  core key accepted
- Dvld  in  1  core output valid

## Operation
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid, latch key, IV and dec into Kin, Din and EncDec, then go to KEY.
  - KEY: Krdy=1. On Kvld=1, go to IV.
  - IV: Drdy=1. On BSY=1, go to RUN.
  - RUN: on Dvld=1, capture Dout into a DOUT_W buffer, clear the word index, and go to SEND.
  - SEND: out_valid=1; out_data = buf[DOUT_W-1-idx*WORD_W -: WORD_W], so the most significant word goes first. Each out_valid&out_ready increments idx. out_last=1 when idx = DOUT_W/WORD_W-1. Acceptance of the last word goes to IDLE.
- Kin, Din and EncDec are held stable from the cycle after acceptance until the next acceptance.
- Krdy and Drdy are never high together.
- EN=0 during reset and 1 at all other times.
- idx is clog2(DOUT_W/WORD_W) bits wide. It never wraps within a block, because SEND exits on the last word.
- req_valid is ignored outside IDLE, and req_ready=0 there.
- A Dvld outside RUN is ignored.
- Kvld and BSY are level-sampled in their own state only.

## Timing
- Reset values: req_ready=0, out_valid=0, out_last=0, out_data=0, err=0, Kin=0, Din=0, EncDec=0, Krdy=0, Drdy=0, EN=0, state IDLE. req_ready=1 on the first cycle after RST drops.
- All outputs are registered.
- Request accepted at edge T: Krdy=1 and Kin/Din/EncDec valid from T+1.
- Kvld sampled high at edge K: Krdy=0 and Drdy=1 from K+1.
- BSY sampled high at edge B: Drdy=0 from B+1.
- Dvld sampled high at edge D: out_valid=1 with word 0 from D+1.
- Word throughput is 1 word/cycle under continuous out_ready.
- When stalled (out_valid=1, out_ready=0), out_data and out_last hold.
- After the last word is accepted at edge L: req_ready=1 from L+1. Minimum turnaround between requests is 1 cycle.
- RST asserted in any state returns to reset values on the next edge. The partial block is discarded and no out_last is produced.

## Configuration
- TRIVIUM_HOST_TIMEOUT_EN defined:
  - A cycle counter is cleared on entry to KEY, IV and RUN.
  - If the counter reaches TIMEOUT in any of these states, Krdy and Drdy drop and err=1 for exactly one cycle.
  - The FSM then returns to IDLE, with req_ready=1 on the following cycle.
- Macro undefined: no counter is built, err is tied to 0, and the host waits indefinitely in each state.

## Test plan
- Nominal run: key FF000102030405060708, IV 0, req_dec=0; core model raises Kvld 3 cycles after Krdy, BSY 2 cycles after Drdy, Dvld 1 cycle after BSY falls. Required: 128 words, first word = Dout[4095:4064], out_last only on word 128, EncDec=0 throughout.
- Backpressure: out_ready toggled pseudo-randomly at 50%. Required: 128 words in order, out_data stable on every stalled cycle, no word duplicated or dropped.
- Back-to-back requests: req_valid held high through SEND with a second key 0123456789ABCDEF0011 and req_dec=1. Required: req_ready=0 until the edge after the last word is accepted; second acceptance on the next cycle; Kin=0123456789ABCDEF0011 and EncDec=1 one cycle later.
- Reset mid-stream: RST for 1 cycle after word 40 is accepted. Required: all outputs at reset values on the next cycle, no out_last, and a new request accepted normally afterwards.
- Timeout with TIMEOUT=16 and the macro defined: Kvld is never asserted. Required: Krdy=1 for 16 cycles, then Krdy=0 and a single-cycle err pulse, then req_ready=1. With the macro undefined, Krdy stays high and err stays 0 for 1000 cycles.
- Spurious core signals: Dvld pulsed while in KEY, and BSY high in IDLE. Required: no state change, out_valid remains 0.
